// File: rtl/mem_arbiter_if.sv
// Core-side port bundle for mem_arbiter: flattened per-core request and response slices,
// slice i of each vector belongs to core i.
interface mem_arbiter_if #(
    parameter int CORE_COUNT = 4,
    parameter int REG_SIZE   = 8,
    parameter int ADDR_SIZE  = 10
);
    logic [2*CORE_COUNT-1:0]         enable_M;
    logic [ADDR_SIZE*CORE_COUNT-1:0] addr_M;
    logic [REG_SIZE*CORE_COUNT-1:0]  wr_data_M;
    logic [REG_SIZE*CORE_COUNT-1:0]  rd_data_M;
    logic [CORE_COUNT-1:0]           ready_M;

    // Handshake: a core holds enable/addr/wr_data stable until the cycle its ready_M bit is
    // high; ready_M is a one-cycle pulse and the core is not considered during that cycle.
    modport master (output enable_M, addr_M, wr_data_M, input rd_data_M, ready_M);
    modport slave  (input enable_M, addr_M, wr_data_M, output rd_data_M, ready_M);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving CORE_COUNT cores single-cycle access to one shared word memory;
// the winner is acked with a registered one-cycle ready pulse on the following cycle.
module mem_arbiter #(
    parameter int CORE_COUNT   = 4,
    parameter int REG_SIZE     = 8,
    parameter int CORE_ID_SIZE = 2,
    parameter int ADDR_SIZE    = CORE_ID_SIZE + REG_SIZE,
    localparam int PTR_W       = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_if.slave     bus,
    output logic [PTR_W-1:0] rr_ptr_dbg
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [1:0] CODE_READ  = 2'b01;
    localparam logic [1:0] CODE_WRITE = 2'b10;

    logic [REG_SIZE-1:0]            mem [DEPTH];
    logic [PTR_W-1:0]               rr_ptr;
    logic [CORE_COUNT-1:0]          ready_q;
    logic [REG_SIZE*CORE_COUNT-1:0] rd_data_q;

    logic [CORE_COUNT-1:0] eligible;
    logic                  gnt_valid;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W:0]        scan_sum;
    logic [PTR_W-1:0]      scan_idx;
    logic [1:0]            gnt_code;
    logic [ADDR_SIZE-1:0]  gnt_addr;
    logic [REG_SIZE-1:0]   gnt_wdata;

    // A core being acked this cycle is excluded so it cannot be served twice per request.
    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            eligible[i] = ((bus.enable_M[2*i +: 2] == CODE_READ) ||
                           (bus.enable_M[2*i +: 2] == CODE_WRITE)) && !ready_q[i];
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(CORE_COUNT)) begin
                scan_sum = scan_sum - (PTR_W+1)'(CORE_COUNT);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!gnt_valid && eligible[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        gnt_code  = bus.enable_M[2*int'(gnt_idx) +: 2];
        gnt_addr  = bus.addr_M[ADDR_SIZE*int'(gnt_idx) +: ADDR_SIZE];
        gnt_wdata = bus.wr_data_M[REG_SIZE*int'(gnt_idx) +: REG_SIZE];
    end

    // The memory array sits in the reset block so no write can land on an edge seen while
    // reset is held; the array itself is deliberately never cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            ready_q   <= '0;
            rd_data_q <= '0;
        end else begin
            ready_q <= '0;
            if (gnt_valid) begin
                ready_q[gnt_idx] <= 1'b1;
                rr_ptr <= (gnt_idx == PTR_W'(CORE_COUNT-1)) ? '0 : gnt_idx + PTR_W'(1);
                if (gnt_code == CODE_WRITE) begin
                    mem[gnt_addr] <= gnt_wdata;
                end else begin
                    rd_data_q[REG_SIZE*int'(gnt_idx) +: REG_SIZE] <= mem[gnt_addr];
                end
            end
        end
    end

    assign bus.ready_M   = ready_q;
    assign bus.rd_data_M = rd_data_q;
    assign rr_ptr_dbg    = rr_ptr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written multi-cycle sequences and a
// randomized run checked against a queue/array reference model.
module tb_mem_arbiter;
  localparam int NC = 4;
  localparam int RS = 8;
  localparam int AS = 10;
  localparam int PW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PW-1:0] rr_ptr_dbg;
  always #5 clk = ~clk;

  mem_arbiter_if #(.CORE_COUNT(NC), .REG_SIZE(RS), .ADDR_SIZE(AS)) bus ();
  mem_arbiter #(.CORE_COUNT(NC), .REG_SIZE(RS), .CORE_ID_SIZE(2), .ADDR_SIZE(AS)) dut (
    .clk(clk), .reset(reset), .bus(bus), .rr_ptr_dbg(rr_ptr_dbg));

  logic [1:0]    code  [NC];
  logic [AS-1:0] addr  [NC];
  logic [RS-1:0] wdata [NC];
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      bus.enable_M[2*i +: 2]    = code[i];
      bus.addr_M[AS*i +: AS]    = addr[i];
      bus.wr_data_M[RS*i +: RS] = wdata[i];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [RS-1:0] m_mem [int];
  logic [NC-1:0] m_ready = '0;
  logic [RS-1:0] m_rd [NC] = '{default: '0};
  bit            m_rd_known [NC] = '{default: 1'b1};
  int            m_rr = 0;
  int            m_win;
  int            m_last_read = -1;
  logic [RS-1:0] exp_q [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready = '0;
      m_rr = 0;
      m_last_read = -1;
      exp_q.delete();
      for (int i = 0; i < NC; i++) begin
        m_rd[i] = '0;
        m_rd_known[i] = 1'b1;
      end
    end else begin
      m_win = -1;
      for (int k = 0; k < NC; k++) begin
        int c;
        c = (m_rr + k) % NC;
        if (m_win < 0 && (code[c] == 2'b01 || code[c] == 2'b10) && !m_ready[c]) m_win = c;
      end
      m_ready = '0;
      m_last_read = -1;
      if (m_win >= 0) begin
        m_ready[m_win] = 1'b1;
        m_rr = (m_win + 1) % NC;
        if (code[m_win] == 2'b10) begin
          m_mem[int'(addr[m_win])] = wdata[m_win];
        end else if (m_mem.exists(int'(addr[m_win]))) begin
          m_rd[m_win] = m_mem[int'(addr[m_win])];
          m_rd_known[m_win] = 1'b1;
          exp_q.push_back(m_rd[m_win]);
          m_last_read = m_win;
        end else begin
          m_rd_known[m_win] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_ready", 64'(bus.ready_M), 64'(m_ready));
      check("model_rr_ptr", 64'(rr_ptr_dbg), 64'(m_rr));
      for (int i = 0; i < NC; i++)
        if (m_rd_known[i]) check($sformatf("model_rd_hold%0d", i),
                                 64'(bus.rd_data_M[RS*i +: RS]), 64'(m_rd[i]));
      if (m_last_read >= 0 && exp_q.size() > 0) begin
        logic [RS-1:0] e;
        e = exp_q.pop_front();
        check($sformatf("sb_rd_ack%0d", m_last_read), 64'(bus.rd_data_M[RS*m_last_read +: RS]), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct packed {
    bit                 rst_before;
    logic [2*NC-1:0]    en;
    logic [AS*NC-1:0]   ad;
    logic [RS*NC-1:0]   wd;
    logic [NC-1:0]      exp_ready;
    logic [NC-1:0]      rd_chk;
    logic [RS*NC-1:0]   exp_rd;
  } vec_t;
  vec_t tbl [19];

  task automatic idle_all();
    for (int i = 0; i < NC; i++) code[i] = 2'b00;
  endtask

  task automatic apply_reset();
    idle_all();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
  endtask

  task automatic drive_vec(input vec_t t);
    for (int i = 0; i < NC; i++) begin
      code[i]  = t.en[2*i +: 2];
      addr[i]  = t.ad[AS*i +: AS];
      wdata[i] = t.wd[RS*i +: RS];
    end
  endtask

  task automatic new_request(input int i);
    int r;
    r = $urandom_range(0, 9);
    code[i] = (r < 2) ? 2'b00 : (r == 2) ? 2'b11 : (r < 7) ? 2'b01 : 2'b10;
    case ($urandom_range(0, 4))
      0: addr[i] = 10'h3FF;
      1: addr[i] = 10'h000;
      2: addr[i] = 10'h012;
      default: addr[i] = AS'($urandom_range(0, 15));
    endcase
    wdata[i] = RS'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AS*NC-1:0] a0;
    logic [AS*NC-1:0] a_all;
    logic [AS*NC-1:0] a_raw2;
    logic [AS*NC-1:0] a_raw1;
    logic [AS*NC-1:0] a_ill;
    a0     = {10'h0, 10'h0, 10'h0, 10'h012};
    a_all  = {10'h012, 10'h012, 10'h012, 10'h012};
    a_raw2 = {10'h0, 10'h3FF, 10'h0, 10'h0};
    a_raw1 = {10'h0, 10'h0, 10'h3FF, 10'h0};
    a_ill  = {10'h0, 10'h0, 10'h100, 10'h012};
    for (int i = 0; i < NC; i++) begin
      code[i] = 2'b00; addr[i] = '0; wdata[i] = '0;
    end

    // single access: write 0xA5 to 0x012 then read it back
    tbl[0]  = '{1'b1, 8'b00000010, a0, 32'h000000A5, 4'b0001, 4'b0001, 32'h00000000};
    tbl[1]  = '{1'b0, 8'b00000001, a0, 32'h0,        4'b0000, 4'b0001, 32'h00000000};
    tbl[2]  = '{1'b0, 8'b00000001, a0, 32'h0,        4'b0001, 4'b0001, 32'h000000A5};
    tbl[3]  = '{1'b0, 8'b00000000, a0, 32'h0,        4'b0000, 4'b0001, 32'h000000A5};
    // contention: all four cores read at once
    tbl[4]  = '{1'b1, 8'b01010101, a_all, 32'h0, 4'b0001, 4'b1111, 32'h000000A5};
    tbl[5]  = '{1'b0, 8'b01010100, a_all, 32'h0, 4'b0010, 4'b1111, 32'h0000A5A5};
    tbl[6]  = '{1'b0, 8'b01010000, a_all, 32'h0, 4'b0100, 4'b1111, 32'h00A5A5A5};
    tbl[7]  = '{1'b0, 8'b01000000, a_all, 32'h0, 4'b1000, 4'b1111, 32'hA5A5A5A5};
    tbl[8]  = '{1'b0, 8'b00000000, a_all, 32'h0, 4'b0000, 4'b1111, 32'hA5A5A5A5};
    // cross-core read-after-write at the top address
    tbl[9]  = '{1'b1, 8'b00100000, a_raw2, 32'h003C0000, 4'b0100, 4'b1111, 32'h00000000};
    tbl[10] = '{1'b0, 8'b00000100, a_raw1, 32'h0,        4'b0010, 4'b1111, 32'h00003C00};
    tbl[11] = '{1'b0, 8'b00000000, a_raw1, 32'h0,        4'b0000, 4'b1111, 32'h00003C00};
    // code 11 on core0 for five cycles while core1 is served
    tbl[12] = '{1'b1, 8'b00001011, a_ill, 32'h00005AFF, 4'b0010, 4'b1111, 32'h00000000};
    tbl[13] = '{1'b0, 8'b00000111, a_ill, 32'h000000FF, 4'b0000, 4'b1111, 32'h00000000};
    tbl[14] = '{1'b0, 8'b00000111, a_ill, 32'h000000FF, 4'b0010, 4'b1111, 32'h00005A00};
    tbl[15] = '{1'b0, 8'b00000011, a_ill, 32'h000000FF, 4'b0000, 4'b1111, 32'h00005A00};
    tbl[16] = '{1'b0, 8'b00000011, a_ill, 32'h000000FF, 4'b0000, 4'b1111, 32'h00005A00};
    tbl[17] = '{1'b0, 8'b00000001, a_ill, 32'h0,        4'b0001, 4'b1111, 32'h00005AA5};
    tbl[18] = '{1'b0, 8'b00000000, a_ill, 32'h0,        4'b0000, 4'b1111, 32'h00005AA5};

    for (int v = 0; v < 19; v++) begin
      if (tbl[v].rst_before) begin
        apply_reset();
        check($sformatf("tbl%0d_reset_ready", v), 64'(bus.ready_M), 64'(0));
        check($sformatf("tbl%0d_reset_rr", v), 64'(rr_ptr_dbg), 64'(0));
      end
      drive_vec(tbl[v]);
      @(negedge clk);
      check($sformatf("tbl%0d_ready", v), 64'(bus.ready_M), 64'(tbl[v].exp_ready));
      for (int i = 0; i < NC; i++)
        if (tbl[v].rd_chk[i]) check($sformatf("tbl%0d_rd%0d", v, i),
                                    64'(bus.rd_data_M[RS*i +: RS]), 64'(tbl[v].exp_rd[RS*i +: RS]));
    end

    // fairness: cores 1 and 3 request back to back for 20 cycles
    apply_reset();
    code[1] = 2'b01; addr[1] = 10'h012;
    code[3] = 2'b01; addr[3] = 10'h3FF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("fair_c%0d", c), 64'(bus.ready_M), (c % 2 == 0) ? 64'h2 : 64'h8);
    end
    idle_all();

    // reset asserted mid-cycle after a write grant edge
    apply_reset();
    code[1] = 2'b01; addr[1] = 10'h012;
    @(negedge clk);
    code[1] = 2'b00;
    code[0] = 2'b10; addr[0] = 10'h055; wdata[0] = 8'h77;
    @(posedge clk); #1;
    check("midrst_pre_ready", 64'(bus.ready_M), 64'h1);
    check("midrst_pre_rd", 64'(bus.rd_data_M), 64'h0000A500);
    #1 reset = 1'b1;
    code[0] = 2'b00;
    #1;
    check("midrst_ready", 64'(bus.ready_M), 64'h0);
    check("midrst_rd", 64'(bus.rd_data_M), 64'h0);
    @(negedge clk); #2 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_ack", 64'(bus.ready_M), 64'h0);
    end
    code[0] = 2'b01;
    @(negedge clk);
    check("post_rst_read_ready", 64'(bus.ready_M), 64'h1);
    check("post_rst_read_data", 64'(bus.rd_data_M[RS-1:0]), 64'h77);
    idle_all();

    // randomized traffic, checked by the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (!((code[i] == 2'b01 || code[i] == 2'b10) && !m_ready[i])) new_request(i);
      end
      if (n == 1500) begin
        #3 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
      end
      @(negedge clk);
    end
    idle_all();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CORE_COUNT, default 4, number of core memory ports served.
REQ-002 Parameter REG_SIZE, default 8, data word width.
REQ-003 Parameter CORE_ID_SIZE, default 2, upper address field width.
REQ-004 Parameter ADDR_SIZE, default CORE_ID_SIZE+REG_SIZE (10), full word address width; memory depth 2^ADDR_SIZE words.
REQ-005 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1, asynchronous, active-high reset.
REQ-007 Port enable_M, input, 2*CORE_COUNT, per-core request code; slice i is bits [2i+1:2i]: 01 = read, 10 = write, 00 and 11 = no request.
REQ-008 Port addr_M, input, ADDR_SIZE*CORE_COUNT, per-core word address, {upper field, offset}, slice i at [ADDR_SIZE*(i+1)-1 : ADDR_SIZE*i].
REQ-009 Port wr_data_M, input, REG_SIZE*CORE_COUNT, per-core write data.
REQ-010 Port rd_data_M, output, REG_SIZE*CORE_COUNT, per-core read data.
REQ-011 Port ready_M, output, CORE_COUNT, per-core completion strobe.

Function
REQ-012 Request protocol: a core holds enable_M, addr_M and wr_data_M stable until the cycle its ready_M bit is 1; it drops or changes the request on the next cycle.
REQ-013 Eligible core: nonzero legal code (01/10) and ready_M[i] currently 0; a core being acked this cycle is not eligible.
REQ-014 Each cycle at most one eligible core is granted, chosen round-robin: scan from rr_ptr upward modulo CORE_COUNT; first eligible wins.
REQ-015 On a grant to core w, rr_ptr <= (w+1) mod CORE_COUNT; with no grant rr_ptr holds.
REQ-016 Granted write: mem[addr] <= wr_data at the end of the grant cycle N.
REQ-017 Granted read: mem[addr] captured into the core's rd_data slice at the end of cycle N.
REQ-018 ready_M[w] = 1 during cycle N+1 only (one-cycle pulse, registered); rd_data slice valid in that cycle and held until the core's next granted read.
REQ-019 Minimum latency: request seen in cycle N, ready in cycle N+1; single-core throughput is one access per 2 cycles; aggregate throughput is one access per cycle.
REQ-020 Ordering: a write granted in cycle N is visible to any read granted in cycle N+1 or later, any core.
REQ-021 Non-granted requesters keep ready_M=0 and wait; round-robin bounds wait to CORE_COUNT-1 grants of other cores.
REQ-022 Writes never modify rd_data_M; ready_M is pulsed for writes exactly as for reads.
REQ-023 Code 11 is ignored: never granted, no ready, no memory change.
REQ-024 Full address width indexes memory; no wrap or truncation; address 2^ADDR_SIZE-1 is legal.

Reset
REQ-025 While reset=1 (asynchronous): ready_M=0, rd_data_M=0, rr_ptr=0, no memory write.
REQ-026 Memory contents are not reset; reads of never-written words return undefined data.
REQ-027 Reset asserted mid-access cancels any pending ack; the cancelled write commits only if its grant edge preceded reset.
REQ-028 After reset deassertion, the first grant is evaluated on the next rising edge with rr_ptr=0.

Verification
REQ-029 Single access: core0 writes 0xA5 to 0x012 at cycle 0, then reads 0x012 -> ready_M[0] at cycles 1 and 3, rd_data slice0 = 0xA5 at cycle 3.
REQ-030 Contention: cores 0–3 all read at cycle 0 with rr_ptr=0 -> grants 0,1,2,3 in cycles 0–3, ready pulses at 1–4, no double ack.
REQ-031 Fairness: cores 1 and 3 issue back-to-back requests continuously for 20 cycles -> grants alternate 1,3,1,3, no gaps; each core acked every 2 cycles.
REQ-032 Cross-core RAW: core2 writes 0x3C to 0x3FF (cycle 0); core1 reads 0x3FF (cycle 1) -> core1 receives 0x3C at cycle 2.
REQ-033 Illegal/idle: core0 drives 11 for 5 cycles -> ready_M[0] stays 0, memory unchanged, other cores served normally.
REQ-034 Reset mid-op: assert reset asynchronously mid-cycle after a grant edge -> ready_M and rd_data_M go to 0 immediately; no ack after release until a new request.
